// File: rtl/aes_pkg.sv
// Shared AES-128 constants: forward S-box, round constants, GF(2^8) xtime.
package aes_pkg;

  localparam int         BLOCK_W = 128;
  localparam logic [3:0] NR      = 4'd10;

  typedef logic [BLOCK_W-1:0] block_t;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [0:9] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // multiply by 2 in GF(2^8), reduced by x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box lookup, one byte.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  assign y = SBOX[a];

endmodule

// File: rtl/aes_cipher.sv
// Iterative AES-128 encryptor: one round per clock, round key expanded
// on the fly alongside the data path.
module aes_cipher
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BLOCK_W-1:0] datain,
  input  logic [BLOCK_W-1:0] key,
  output logic [BLOCK_W-1:0] dataout,
  output logic [BLOCK_W-1:0] keyout,
  output logic               busy,
  output logic               done
);

  // state | meaning
  // IDLE  | waiting for start; dataout/keyout hold the last result
  // RUN   | applying round round_q (1..10), next key computed alongside
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]   fsm_q;
  logic [3:0]   round_q;
  block_t       st_q;
  block_t       rk_q;
  block_t       sb;
  block_t       sr;
  block_t       mc;
  block_t       nk;
  block_t       round_out;
  logic [31:0]  rot_w;
  logic [31:0]  sub_w;
  logic [3:0]   rcon_idx;
  logic [7:0]   rcon;

  function automatic block_t shift_rows(input block_t s);
    block_t r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(row+4*c) -: 8] = s[127-8*(row+4*((c+row)%4)) -: 8];
      end
    end
    return r;
  endfunction

  function automatic block_t mix_columns(input block_t s);
    block_t     r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  // sw is SubWord(RotWord(last word)) of the current key
  function automatic block_t key_next(input block_t rk, input logic [31:0] sw,
                                      input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = rk[127:96] ^ sw ^ {rc, 24'h000000};
    w1 = rk[95:64] ^ w0;
    w2 = rk[63:32] ^ w1;
    w3 = rk[31:0]  ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  for (genvar i = 0; i < 16; i++) begin : g_sub_bytes
    aes_sbox u_sbox (
      .a (st_q[127-8*i -: 8]),
      .y (sb[127-8*i -: 8])
    );
  end

  assign rot_w = {rk_q[23:0], rk_q[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sub_word
    aes_sbox u_sbox (
      .a (rot_w[31-8*i -: 8]),
      .y (sub_w[31-8*i -: 8])
    );
  end

  // round_q is 0 while idle; clamp so the table index stays in range
  assign rcon_idx  = (round_q >= 4'd1 && round_q <= NR) ? round_q - 4'd1 : 4'd0;
  assign rcon      = RCON[rcon_idx];
  assign nk        = key_next(rk_q, sub_w, rcon);
  assign sr        = shift_rows(sb);
  assign mc        = mix_columns(sr);
  assign round_out = (round_q == NR) ? (sr ^ nk) : (mc ^ nk);
  assign busy      = (fsm_q == ST_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= ST_IDLE;
      round_q <= 4'd0;
      st_q    <= '0;
      rk_q    <= '0;
      dataout <= '0;
      keyout  <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (fsm_q)
        ST_IDLE: begin
          if (start) begin
            st_q    <= datain ^ key;
            rk_q    <= key;
            round_q <= 4'd1;
            fsm_q   <= ST_RUN;
          end
        end
        ST_RUN: begin
          st_q <= round_out;
          rk_q <= nk;
          if (round_q == NR) begin
            dataout <= round_out;
            keyout  <= nk;
            done    <= 1'b1;
            round_q <= 4'd0;
            fsm_q   <= ST_IDLE;
          end else begin
            round_q <= round_q + 4'd1;
          end
        end
        default: fsm_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_cipher.sv
// Directed bench for aes_cipher with a scoreboard fed by known answers
// and an independent byte-oriented AES-128 reference.
module tb_aes_cipher;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] datain;
  logic [127:0] key;
  logic [127:0] dataout;
  logic [127:0] keyout;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  aes_cipher dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .datain  (datain),
    .key     (key),
    .dataout (dataout),
    .keyout  (keyout),
    .busy    (busy),
    .done    (done)
  );

  typedef struct {
    string        tag;
    logic [127:0] ct;
    logic [127:0] lk;
  } exp_t;

  exp_t         sbq[$];
  int           npass  = 0;
  int           ntotal = 0;
  logic [7:0]   msbox [256];

  localparam logic [127:0] K1  = 128'h5468617473206D79204B756E67204675;
  localparam logic [127:0] P1  = 128'h54776F204F6E65204E696E652054776F;
  localparam logic [127:0] C1  = 128'h29C3505F571420F6402299B31A02D73A;
  localparam logic [127:0] L1  = 128'h28FDDEF86DA4244ACCC0A4FE3B316F26;
  localparam logic [127:0] K2  = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] P2  = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] C2  = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
  localparam logic [127:0] L2  = 128'h13111D7FE3944A17F307A78B4D2B30C5;
  localparam logic [127:0] PH  = 128'h48656C6C6F20576F726C642120202020;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from the multiplicative inverse plus the affine map
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      msbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                 {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [127:0] k,
                                             output logic [127:0] lk);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] out;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {msbox[tmp[31:24]], msbox[tmp[23:16]], msbox[tmp[15:8]], msbox[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h000000};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = msbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) t[rr+4*c] = s[rr+4*((c+rr)%4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
    lk = {w[40], w[41], w[42], w[43]};
    return out;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // called at a negedge; returns at the negedge after the sampling edge
  task automatic do_start(input logic [127:0] d, input logic [127:0] k);
    datain = d;
    key    = k;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic push_exp(input string tag, input logic [127:0] ct, input logic [127:0] lk);
    exp_t e;
    e.tag = tag;
    e.ct  = ct;
    e.lk  = lk;
    sbq.push_back(e);
  endtask

  task automatic push_model(input string tag, input logic [127:0] d, input logic [127:0] k);
    logic [127:0] ct, lk;
    ct = aes_model(d, k, lk);
    push_exp(tag, ct, lk);
  endtask

  // waits (bounded) for done, checks outputs held meanwhile, pops scoreboard
  task automatic wait_done(output int lat);
    logic [127:0] held_d, held_k;
    logic         moved;
    exp_t         e;
    held_d = dataout;
    held_k = keyout;
    moved  = 1'b0;
    lat    = 0;
    while (!done && lat < 40) begin
      if (dataout !== held_d || keyout !== held_k) moved = 1'b1;
      @(negedge clk);
      lat++;
    end
    check("done_seen", {127'd0, done}, 128'd1);
    check("held_while_busy", {127'd0, moved}, 128'd0);
    if (done) begin
      if (sbq.size() == 0) begin
        ntotal++;
        $error("FAIL scoreboard: done with no expected entry, observed %h", dataout);
      end else begin
        e = sbq.pop_front();
        check({e.tag, "_dataout"}, dataout, e.ct);
        check({e.tag, "_keyout"}, keyout, e.lk);
      end
    end
  endtask

  initial begin
    int           lat;
    int           ndone;
    logic [127:0] rd, rk;

    rst    = 1'b1;
    start  = 1'b0;
    datain = '0;
    key    = '0;
    build_sbox();

    repeat (3) @(negedge clk);
    check("rst_dataout", dataout, 128'd0);
    check("rst_keyout", keyout, 128'd0);
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_done", {127'd0, done}, 128'd0);
    rst = 1'b0;
    @(negedge clk);

    // known-answer block
    push_exp("kat", C1, L1);
    do_start(P1, K1);
    check("busy_after_start", {127'd0, busy}, 128'd1);
    wait_done(lat);
    check("kat_latency", 128'(lat), 128'd10);
    @(negedge clk);
    check("done_one_cycle", {127'd0, done}, 128'd0);
    check("busy_after_done", {127'd0, busy}, 128'd0);

    // FIPS-197 C.1, inputs scrambled right after the start edge
    push_exp("fips", C2, L2);
    do_start(P2, K2);
    datain = ~P2;
    key    = 128'hDEADBEEF_01234567_89ABCDEF_FEEDF00D;
    wait_done(lat);
    check("fips_latency", 128'(lat), 128'd10);
    @(negedge clk);

    // second start at cycle 3 must be ignored
    push_exp("ignore", C1, L1);
    do_start(P1, K1);
    @(negedge clk);
    do_start(PH, K2);
    wait_done(lat);
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("ignore_single_done", 128'(ndone), 128'd0);

    // reset mid-operation: outputs clear and no done follows
    do_start(P2, K2);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_dataout", dataout, 128'd0);
    check("abort_keyout", keyout, 128'd0);
    check("abort_busy", {127'd0, busy}, 128'd0);
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", 128'(ndone), 128'd0);

    // back-to-back: restart in the done cycle
    push_exp("b2b_first", C1, L1);
    do_start(P1, K1);
    wait_done(lat);
    push_model("b2b_second", PH, K1);
    do_start(PH, K1);
    check("b2b_first_held", dataout, C1);
    wait_done(lat);
    check("b2b_gap", 128'(lat + 1), 128'd11);
    @(negedge clk);

    // random blocks against the reference model
    repeat (2) begin
      rd = {$urandom, $urandom, $urandom, $urandom};
      rk = {$urandom, $urandom, $urandom, $urandom};
      push_model("rand", rd, rk);
      do_start(rd, rk);
      wait_done(lat);
      check("rand_latency", 128'(lat), 128'd10);
      @(negedge clk);
    end

    check("scoreboard_drained", 128'(sbq.size()), 128'd0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/aes_cipher.md
AES_CIPHER -- requirements
Module: aes_cipher

Interface
REQ-001 SHALL have no parameters; AES-128 only (Nk=4, Nr=10, 128-bit block).
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  one-cycle request; samples datain and key.
REQ-006 datain  input  128  plaintext block; bit 127 is byte 0 of the FIPS-197 input.
REQ-007 key  input  128  cipher key; bit 127 is key byte 0.
REQ-008 dataout  output  128  ciphertext, same byte order as datain.
REQ-009 keyout  output  128  last round key (round 10) of the expansion.
REQ-010 busy  output  1  high while an encryption is in progress.
REQ-011 done  output  1  one-cycle pulse when dataout and keyout become valid.

Function
REQ-012 SHALL implement FIPS-197 AES-128 encryption: initial AddRoundKey, rounds 1-9 (SubBytes, ShiftRows, MixColumns, AddRoundKey), and round 10 without MixColumns.
REQ-013 SHALL be iterative, with one round per clock and on-the-fly key expansion (RotWord, SubWord, Rcon 01,02,04,08,10,20,40,80,1B,36).
REQ-014 On a start edge (E0) with busy=0: state <= datain^key, round key <= key, round counter <= 1, busy <= 1.
REQ-015 On edges E1..E10: the round selected by the counter is applied and the next round key is computed in the same cycle.
REQ-016 After E10: dataout <= final state, keyout <= round-10 key, busy <= 0, done <= 1 for exactly one cycle.
REQ-017 Latency from the start edge to done high SHALL be 10 clocks; throughput SHALL be one block per 11 clocks.
REQ-018 dataout and keyout SHALL hold their values until the next completion; they SHALL NOT change during busy.
REQ-019 start while busy=1 SHALL be ignored.
REQ-020 start in the cycle done=1 SHALL be accepted, giving back-to-back operation.
REQ-021 datain and key SHALL be sampled only at the start edge; later changes have no effect on the operation in flight.
REQ-022 GF(2^8) multiply by 2 SHALL use xtime with reduction polynomial 0x11B.

Reset
REQ-023 When rst=1 at a clock edge: dataout=0, keyout=0, busy=0, done=0, round counter=0, internal state/key=0.
REQ-024 rst SHALL take priority over start.
REQ-025 Reset during busy SHALL abort the operation with no done pulse.

Structure
REQ-026 A shared package aes_pkg SHALL hold the 256-entry S-box constant table, the Rcon table, and the constants NR=10 and BLOCK_W=128.
REQ-027 One sub-module aes_sbox (8-bit combinational lookup) SHALL be used: 16 instances for SubBytes and 4 for SubWord.
REQ-028 ShiftRows, MixColumns and key expansion SHALL be combinational functions in aes_cipher; no other sub-modules.

Verification
REQ-029 Known-answer test: key 5468617473206D79204B756E67204675, datain 54776F204F6E65204E696E652054776F, start -> 10 clocks later done=1, dataout=29C3505F571420F6402299B31A02D73A, keyout=28FDDEF86DA4244ACCC0A4FE3B316F26.
REQ-030 FIPS-197 C.1 test: key 000102030405060708090A0B0C0D0E0F, datain 00112233445566778899AABBCCDDEEFF -> dataout 69C4E0D86A7B0430D8CDB78070B4C55A, keyout 13111D7FE3944A17F307A78B4D2B30C5.
REQ-031 Reset check: assert rst mid-operation (cycle 5) -> dataout=0, keyout=0, busy=0, and no done pulse follows.
REQ-032 Ignore check: pulse start again at cycle 3 with different data -> the result is still that of the first block, with a single done pulse.
REQ-033 Back-to-back check: start in the done cycle with key 5468617473206D79204B756E67204675 and datain 48656C6C6F20576F726C642120202020 -> second done exactly 11 clocks after the first, with dataout equal to a software AES model result and the first result held until then.
